// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
// Groups the control and status signals of the instruction-fetch controller.
//   master : program sequencer side (drives start/stall/branch/halt controls,
//            observes the PC and status)
//   slave  : fetch_ctrl side
// Signals
//   start, start_addr[D]     begin execution at start_addr
//   stall                    hold the current instruction
//   branch_en, branch_abs,   taken branch; absolute target or signed offset
//   target[D]
//   halt                     current instruction is halt
//   prog_ctr[D]              instruction ROM address
//   fetch_valid, done        RUN / HALTED state decodes
//   pc_wrap                  sticky: PC incremented past 2**D-1
//   instr_count[CNT_W]       retired-instruction count (saturating)
// -----------------------------------------------------------------------------
interface fetch_ctrl_if #(
    parameter int D     = 10,
    parameter int CNT_W = 16
);
    logic             start;
    logic [D-1:0]     start_addr;
    logic             stall;
    logic             branch_en;
    logic             branch_abs;
    logic [D-1:0]     target;
    logic             halt;
    logic [D-1:0]     prog_ctr;
    logic             fetch_valid;
    logic             done;
    logic             pc_wrap;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output start, start_addr, stall, branch_en, branch_abs, target, halt,
        input  prog_ctr, fetch_valid, done, pc_wrap, instr_count
    );

    modport slave (
        input  start, start_addr, stall, branch_en, branch_abs, target, halt,
        output prog_ctr, fetch_valid, done, pc_wrap, instr_count
    );
endinterface

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Program-counter sequencer for a 2**D x 9-bit instruction ROM.
// Three states: IDLE (waiting for start), RUN (fetching), HALTED (after halt).
// In RUN the per-cycle priority is stall > halt > branch > increment.
// Ports
//   clk      : clock, rising-edge
//   reset_n  : asynchronous active-low reset
//   bus      : fetch_ctrl_if.slave (controls in, PC/status out)
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int D     = 10,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    fetch_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [D-1:0]     PC_ONE  = {{(D-1){1'b0}}, 1'b1};
    localparam logic [D-1:0]     PC_LAST = {D{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [D-1:0]     pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        wrap_d  = wrap_q;

        case (state_q)
            IDLE, HALTED: begin
                // Only start is honoured outside RUN; a restart clears the
                // program's statistics.
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = bus.start_addr;
                    cnt_d   = '0;
                    wrap_d  = 1'b0;
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    // Every non-stalled RUN cycle retires one instruction,
                    // including the halt itself.
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    if (bus.halt) begin
                        state_d = HALTED;
                    end else if (bus.branch_en) begin
                        // Two's-complement offset add wraps modulo 2**D by
                        // truncation; relative branches never touch pc_wrap.
                        pc_d = bus.branch_abs ? bus.target : (pc_q + bus.target);
                    end else begin
                        pc_d = pc_q + PC_ONE;
                        if (pc_q == PC_LAST) begin
                            wrap_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.prog_ctr    = pc_q;
    assign bus.fetch_valid = (state_q == RUN);
    assign bus.done        = (state_q == HALTED);
    assign bus.pc_wrap     = wrap_q;
    assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed bench for fetch_ctrl: a table of per-cycle vectors with expected
// outputs, plus hand-written sequences for asynchronous reset and counter
// saturation (the latter on a small D=4, CNT_W=3 instance).
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;
    logic clk;
    logic reset_n;

    fetch_ctrl_if #(.D(10), .CNT_W(16)) bus ();
    fetch_ctrl_if #(.D(4),  .CNT_W(3))  sbus ();

    fetch_ctrl #(.D(10), .CNT_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    fetch_ctrl #(.D(4), .CNT_W(3)) dut_s (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        start;
        logic [9:0]  start_addr;
        logic        stall;
        logic        branch_en;
        logic        branch_abs;
        logic [9:0]  target;
        logic        halt;
        logic [9:0]  exp_pc;
        logic        exp_valid;
        logic        exp_done;
        logic        exp_wrap;
        logic [15:0] exp_cnt;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic st, input logic [9:0] sa, input logic stl,
        input logic be, input logic ba, input logic [9:0] tg, input logic hl,
        input logic [9:0] pc, input logic v, input logic d, input logic w,
        input logic [15:0] c);
        vec_t r;
        r.start = st; r.start_addr = sa; r.stall = stl;
        r.branch_en = be; r.branch_abs = ba; r.target = tg; r.halt = hl;
        r.exp_pc = pc; r.exp_valid = v; r.exp_done = d; r.exp_wrap = w;
        r.exp_cnt = c;
        return r;
    endfunction

    task automatic drive(input logic st, input logic [9:0] sa, input logic stl,
                         input logic be, input logic ba, input logic [9:0] tg,
                         input logic hl);
        bus.start = st; bus.start_addr = sa; bus.stall = stl;
        bus.branch_en = be; bus.branch_abs = ba; bus.target = tg; bus.halt = hl;
    endtask

    task automatic check_all(input string tag, input logic [9:0] pc, input logic v,
                             input logic d, input logic w, input logic [15:0] c);
        check({tag, ".pc"},    32'(bus.prog_ctr),    32'(pc));
        check({tag, ".valid"}, 32'(bus.fetch_valid), 32'(v));
        check({tag, ".done"},  32'(bus.done),        32'(d));
        check({tag, ".wrap"},  32'(bus.pc_wrap),     32'(w));
        check({tag, ".cnt"},   32'(bus.instr_count), 32'(c));
    endtask

    initial begin
        //               st sa     stl be ba tg     hl   pc     v  d  w  cnt
        vecs[0]  = mk(0, 10'h000, 0, 1, 1, 10'h055, 1,  10'h000, 0, 0, 0, 0);  // IDLE ignores controls
        vecs[1]  = mk(1, 10'h005, 0, 0, 0, 10'h000, 0,  10'h005, 1, 0, 0, 0);  // start
        vecs[2]  = mk(0, 10'h000, 0, 0, 0, 10'h000, 0,  10'h006, 1, 0, 0, 1);
        vecs[3]  = mk(0, 10'h000, 0, 0, 0, 10'h000, 0,  10'h007, 1, 0, 0, 2);
        vecs[4]  = mk(0, 10'h000, 0, 0, 0, 10'h000, 0,  10'h008, 1, 0, 0, 3);
        vecs[5]  = mk(0, 10'h000, 0, 1, 1, 10'h010, 0,  10'h010, 1, 0, 0, 4);  // abs -> 0x010
        vecs[6]  = mk(0, 10'h000, 0, 1, 0, 10'h3FD, 0,  10'h00D, 1, 0, 0, 5);  // rel -3
        vecs[7]  = mk(0, 10'h000, 0, 1, 1, 10'h200, 0,  10'h200, 1, 0, 0, 6);  // abs 0x200
        vecs[8]  = mk(0, 10'h000, 0, 1, 1, 10'h020, 0,  10'h020, 1, 0, 0, 7);
        vecs[9]  = mk(0, 10'h000, 1, 1, 1, 10'h100, 1,  10'h020, 1, 0, 0, 7);  // stall wins
        vecs[10] = mk(0, 10'h000, 1, 1, 1, 10'h100, 1,  10'h020, 1, 0, 0, 7);
        vecs[11] = mk(0, 10'h000, 0, 1, 1, 10'h100, 1,  10'h020, 0, 1, 0, 8);  // halt over branch
        vecs[12] = mk(0, 10'h000, 0, 1, 1, 10'h055, 0,  10'h020, 0, 1, 0, 8);  // HALTED holds
        vecs[13] = mk(1, 10'h3FE, 0, 0, 0, 10'h000, 0,  10'h3FE, 1, 0, 0, 0);  // restart
        vecs[14] = mk(0, 10'h000, 0, 1, 0, 10'h003, 0,  10'h001, 1, 0, 0, 1);  // rel across top, no wrap
        vecs[15] = mk(0, 10'h000, 0, 1, 1, 10'h3FE, 0,  10'h3FE, 1, 0, 0, 2);
        vecs[16] = mk(0, 10'h000, 0, 0, 0, 10'h000, 0,  10'h3FF, 1, 0, 0, 3);
        vecs[17] = mk(0, 10'h000, 0, 0, 0, 10'h000, 0,  10'h000, 1, 0, 1, 4);  // increment wraps
        vecs[18] = mk(0, 10'h000, 0, 0, 0, 10'h000, 0,  10'h001, 1, 0, 1, 5);  // sticky
        vecs[19] = mk(1, 10'h100, 0, 0, 0, 10'h000, 0,  10'h002, 1, 0, 1, 6);  // start ignored in RUN
        vecs[20] = mk(0, 10'h000, 0, 0, 0, 10'h000, 1,  10'h002, 0, 1, 1, 7);  // halt
        vecs[21] = mk(0, 10'h000, 1, 1, 1, 10'h0AA, 1,  10'h002, 0, 1, 1, 7);  // HALTED holds
        vecs[22] = mk(1, 10'h040, 0, 0, 0, 10'h000, 0,  10'h040, 1, 0, 0, 0);  // restart clears

        reset_n = 1'b0;
        drive(0, 10'h000, 0, 0, 0, 10'h000, 0);
        sbus.start = 0; sbus.start_addr = '0; sbus.stall = 0;
        sbus.branch_en = 0; sbus.branch_abs = 0; sbus.target = '0; sbus.halt = 0;

        repeat (2) @(negedge clk);
        check_all("reset", 10'h000, 0, 0, 0, 0);
        reset_n = 1'b1;

        // Asynchronous reset in the middle of RUN, with wrap and count non-zero.
        @(negedge clk); drive(1, 10'h3FF, 0, 0, 0, 10'h000, 0);
        @(posedge clk); #1;
        check("arst.start_pc", 32'(bus.prog_ctr), 32'h3FF);
        @(negedge clk); drive(0, 10'h000, 0, 0, 0, 10'h000, 0);
        @(posedge clk); #1;
        check_all("arst.wrap", 10'h000, 1, 0, 1, 1);
        @(negedge clk); drive(0, 10'h000, 0, 1, 1, 10'h123, 0);
        @(posedge clk); #1;
        check_all("arst.at123", 10'h123, 1, 0, 1, 2);
        @(negedge clk); drive(0, 10'h000, 0, 0, 0, 10'h000, 0);
        #2 reset_n = 1'b0;
        #1 check_all("arst.async", 10'h000, 0, 0, 0, 0);
        @(negedge clk); reset_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check_all("arst.idle", 10'h000, 0, 0, 0, 0);
        end
        @(negedge clk); drive(1, 10'h007, 0, 0, 0, 10'h000, 0);
        @(posedge clk); #1;
        check_all("arst.first_edge", 10'h007, 1, 0, 0, 0);

        // Back to IDLE for the vector table.
        @(negedge clk); drive(0, 10'h000, 0, 0, 0, 10'h000, 0); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].start, vecs[i].start_addr, vecs[i].stall, vecs[i].branch_en,
                  vecs[i].branch_abs, vecs[i].target, vecs[i].halt);
            @(posedge clk); #1;
            check_all($sformatf("v%0d", i), vecs[i].exp_pc, vecs[i].exp_valid,
                      vecs[i].exp_done, vecs[i].exp_wrap, vecs[i].exp_cnt);
        end
        @(negedge clk); drive(0, 10'h000, 0, 0, 0, 10'h000, 0);

        // Counter saturation on the narrow instance: 10 retired, 3-bit counter.
        @(negedge clk); sbus.start = 1; sbus.start_addr = 4'h0;
        @(negedge clk); sbus.start = 0;
        repeat (10) @(negedge clk);
        check("sat.cnt", 32'(sbus.instr_count), 32'd7);
        check("sat.pc",  32'(sbus.prog_ctr),    32'd10);
        sbus.halt = 1;
        @(negedge clk); sbus.halt = 0;
        check("sat.done",     32'(sbus.done),        32'd1);
        check("sat.halt_cnt", 32'(sbus.instr_count), 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
